// File: rtl/uart_rx_vote.sv
// Majority-voting UART receiver: 2-flop synchroniser, start-bit qualification,
// 2-of-3 vote around mid-bit, framing check. Optional even parity: UART_RX_PARITY_EN.
module uart_rx_vote #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       rx_serial_input,
  output logic [7:0] rx_output,
  output logic       rx_data_valid,
  output logic       rx_frame_error,
  output logic       rx_parity_error,
  output logic       rx_busy
);

  localparam int MID = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] SAMP0_AT = 16'(MID - 1);
  localparam logic [15:0] SAMP1_AT = 16'(MID);
  localparam logic [15:0] VOTE_AT  = 16'(MID + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;
`endif

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  samp_q, samp_d;
  logic [7:0]  out_q, out_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        s, vote, at_vote, cnt_wrap;

  assign s        = sync2_q;
  assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & s) | (samp_q[1] & s);
  assign at_vote  = (cnt_q == VOTE_AT);
  assign cnt_wrap = (cnt_q == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic par_bad_q, par_bad_d;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      samp_q    <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      sync1_q   <= rx_serial_input;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif

    // Bit-phase counting and the two early samples are common to all in-frame states.
    if (state_q != IDLE && state_q != BRK) begin
      cnt_d = cnt_wrap ? 16'd0 : cnt_q + 16'd1;
      if (cnt_q == SAMP0_AT) samp_d[0] = s;
      if (cnt_q == SAMP1_AT) samp_d[1] = s;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!s) state_d = START;
      end
      START: begin
        if (at_vote && vote) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_wrap) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (at_vote) shift_d[idx_q] = vote;
        if (cnt_wrap) begin
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_vote) par_bad_d = vote ^ (^shift_q);
        if (cnt_wrap) state_d = STOP;
      end
`endif
      STOP: begin
        // Decide at mid stop bit so a following start edge is never missed.
        if (at_vote) begin
          cnt_d = '0;
          if (vote) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              out_d   = shift_q;
              valid_d = 1'b1;
            end
`else
            out_d   = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            state_d = BRK;
            ferr_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_output      = out_q;
  assign rx_data_valid  = valid_q;
  assign rx_frame_error = ferr_q;
  assign rx_busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_parity_error = perr_q;
`else
  assign rx_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_vote.sv
// Bench for uart_rx_vote: frame-level event model (pulse cycles, busy windows,
// held byte) compared every cycle, plus hand-computed literal checks.
module tb_uart_rx_vote;

  localparam int CPB = 87;
  localparam int MID = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB      = 11;
  localparam int LAT_LIT = 915;
  localparam int GAP_LIT = 957;
`else
  localparam int NB      = 10;
  localparam int LAT_LIT = 828;
  localparam int GAP_LIT = 870;
`endif
  // Offset from the cycle the line falls to the decision pulse: 3 cycles of
  // synchroniser/IDLE detection, then all bits before stop, then mid stop bit.
  localparam int DEC = 3 + (NB - 1) * CPB + MID + 2;
  localparam int NEVER = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line;
  logic [7:0] rx_output;
  logic       rx_data_valid, rx_frame_error, rx_parity_error, rx_busy;

  uart_rx_vote #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock         (clk),
    .i_Rst_n         (rst_n),
    .rx_serial_input (line),
    .rx_output       (rx_output),
    .rx_data_valid   (rx_data_valid),
    .rx_frame_error  (rx_frame_error),
    .rx_parity_error (rx_parity_error),
    .rx_busy         (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         v;
    bit         fe;
    bit         pe;
    logic [7:0] d;
  } ev_t;

  ev_t        ev_q[$];
  int         b_from[$];
  int         b_to[$];
  logic [7:0] exp_out = 8'h00;
  int         vcyc_q[$];
  logic [7:0] vdat_q[$];
  int         fcnt = 0, pcnt = 0, bcnt = 0;
  int         n_chk = 0, n_fail = 0;
  int         last_p = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Compare process: expected outputs derived from the frame-level event list.
  always @(negedge clk) begin : cmp
    ev_t  e;
    logic ev, efe, epe, eb;
    ev = 1'b0; efe = 1'b0; epe = 1'b0; eb = 1'b0;
    if (!rst_n) begin
      exp_out = 8'h00;
    end else begin
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        e   = ev_q.pop_front();
        ev  = e.v;
        efe = e.fe;
        epe = e.pe;
        if (e.v) exp_out = e.d;
      end
      for (int i = 0; i < b_from.size(); i++)
        if (cyc >= b_from[i] && cyc <= b_to[i]) eb = 1'b1;
      if (rx_data_valid) begin
        vcyc_q.push_back(cyc);
        vdat_q.push_back(rx_output);
      end
      if (rx_frame_error) fcnt++;
      if (rx_parity_error) pcnt++;
      if (rx_busy) bcnt++;
    end
    chk("valid", rx_data_valid, ev);
    chk("frame_err", rx_frame_error, efe);
    chk("parity_err", rx_parity_error, epe);
    chk("busy", rx_busy, eb);
    chk("rx_output", rx_output, exp_out);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A glitched bit flips the line for one cycle so that it hits one sample point.
  task automatic drive_bit(input logic b, input bit glitch);
    if (glitch) begin
      line = b;  tick(45);
      line = ~b; tick(1);
      line = b;  tick(CPB - 46);
    end else begin
      line = b;  tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop,
                            input int glitch_bit);
    ev_t e;
    bit  pbad;
    int  p;
    p = cyc;
`ifdef UART_RX_PARITY_EN
    pbad = !par_ok;
`else
    pbad = 1'b0;
`endif
    e.cyc = p + DEC;
    e.v   = stop && !pbad;
    e.fe  = !stop;
    e.pe  = pbad;
    e.d   = d;
    ev_q.push_back(e);
    b_from.push_back(p + 3);
    b_to.push_back(stop ? p + DEC - 1 : NEVER);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], i == glitch_bit);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ !par_ok, 1'b0);
`endif
    drive_bit(stop, 1'b0);
    last_p = p;
  endtask

  initial begin : stim
    int p, r;
    logic [7:0] b3f;
    rst_n = 1'b0;
    line  = 1'b1;
    tick(5);
    chk("reset_output", rx_output, 8'h00);
    chk("reset_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    tick(10);

    // Single clean byte and its latency.
    send_frame(8'hAB, 1'b1, 1'b1, -1);
    p = last_p;
    tick(50);
    chk("ab_valid_count", vcyc_q.size(), 1);
    chk("ab_latency", (vcyc_q.size() > 0) ? vcyc_q[0] - (p + 3) : -1, LAT_LIT);
    chk("ab_data", rx_output, 8'hAB);
    chk("ab_no_errors", fcnt + pcnt, 0);

    // Short low pulse: start bit rejected.
    vcyc_q.delete(); vdat_q.delete();
    bcnt = 0;
    p = cyc;
    b_from.push_back(p + 3);
    b_to.push_back(p + 47);
    line = 1'b0; tick(20);
    line = 1'b1; tick(200);
    chk("glitch_busy_window", (bcnt >= 44 && bcnt <= 46), 1'b1);
    chk("glitch_no_valid", vcyc_q.size(), 0);

    // Back-to-back frames with one stop bit each.
    send_frame(8'h3F, 1'b1, 1'b1, -1);
    send_frame(8'hC0, 1'b1, 1'b1, -1);
    tick(50);
    chk("b2b_count", vcyc_q.size(), 2);
    chk("b2b_gap", (vcyc_q.size() > 1) ? vcyc_q[1] - vcyc_q[0] : -1, GAP_LIT);
    chk("b2b_first", (vdat_q.size() > 0) ? vdat_q[0] : 8'hxx, 8'h3F);
    chk("b2b_second", rx_output, 8'hC0);

    // Stop bit low, line then held low (break).
    vcyc_q.delete(); vdat_q.delete();
    fcnt = 0;
    send_frame(8'h55, 1'b1, 1'b0, -1);
    tick(2000);
    chk("break_busy_held", rx_busy, 1'b1);
    r = cyc;
    line = 1'b1;
    b_to[b_to.size() - 1] = r + 2;
    tick(100);
    chk("break_ferr_count", fcnt, 1);
    chk("break_no_valid", vcyc_q.size(), 0);
    chk("break_output_kept", rx_output, 8'hC0);

    // Single-cycle glitch at a sample point of data bit 2.
    send_frame(8'hA5, 1'b1, 1'b1, 2);
    tick(50);
    chk("vote_tolerance", rx_output, 8'hA5);

    // Reset in the middle of data bit 4 of 0x3F, then a clean 0x12.
    vcyc_q.delete(); vdat_q.delete();
    b3f = 8'h3F;
    p = cyc;
    b_from.push_back(p + 3);
    b_to.push_back(NEVER);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b3f[i], 1'b0);
    line = b3f[4];
    tick(40);
    r = cyc;
    b_to[b_to.size() - 1] = r - 1;
    rst_n = 1'b0;
    line  = 1'b1;
    tick(5);
    chk("midreset_output", rx_output, 8'h00);
    chk("midreset_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    tick(20);
    send_frame(8'h12, 1'b1, 1'b1, -1);
    tick(50);
    chk("after_reset_count", vcyc_q.size(), 1);
    chk("after_reset_data", rx_output, 8'h12);

`ifdef UART_RX_PARITY_EN
    vcyc_q.delete(); vdat_q.delete();
    pcnt = 0;
    send_frame(8'h07, 1'b1, 1'b1, -1);
    p = last_p;
    tick(50);
    chk("par_ok_latency", (vcyc_q.size() > 0) ? vcyc_q[0] - (p + 3) : -1, 915);
    chk("par_ok_data", rx_output, 8'h07);
    send_frame(8'h07, 1'b0, 1'b1, -1);
    tick(50);
    chk("par_bad_pulse", pcnt, 1);
    chk("par_bad_no_valid", vcyc_q.size(), 1);
`endif

    chk("events_consumed", ev_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
